fft_frame_scheduler: RTL and testbench

// Frame-level controller for the 8-point FFT datapath. Accepts a host sample stream (valid/ready),

---
 rtl/fft_frame_scheduler_if.sv | 17 +
 rtl/fft_frame_scheduler.sv | 164 ++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_scheduler_if.sv
// Host sample stream for the FFT frame scheduler.
//   s_valid      host beat valid
//   s_ready      scheduler can take a beat; beat moves when s_valid && s_ready
//   s_real_mode  1 = real sample, 0 = alternating re/im parts
//   s_data       beat payload
// master = host side, slave = scheduler side.
interface fft_frame_scheduler_if #(
  parameter int INPUT_SIZE = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_real_mode;
  logic [INPUT_SIZE-1:0] s_data;

  modport master (output s_valid, output s_real_mode, output s_data, input s_ready);
  modport slave  (input s_valid, input s_real_mode, input s_data, output s_ready);
endinterface

// File: rtl/fft_frame_scheduler.sv
// Frame-level controller for the 8-point FFT datapath.
// Meters one frame of host beats into the deserializer, launches the FFT
// core once the deserializer reports a full array, then hands the result to
// the output serializer. Provides backpressure, frame-mode consistency
// checking, a compute timeout and a completed-frame counter.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   host            host stream (slave side of fft_frame_scheduler_if)
//   des_valid/des_real_mode/des_data  registered beat forward to deserializer
//   des_done        deserializer array complete
//   fft_start       one-cycle pulse, FFT core captures the array
//   fft_done        FFT core result ready
//   ser_load        one-cycle pulse, serializer loads the result
//   ser_busy        serializer still shifting the previous frame
//   err_clear       synchronous clear of the sticky error flags
//   busy            controller is not idle
//   err_mode        sticky: a beat's mode differed from the frame mode
//   err_timeout     sticky: FFT core did not answer within TIMEOUT_CYCLES
//   frame_count     frames handed to the serializer (wraps)
// All pulse outputs are registered: they appear the cycle after the input
// event that causes them.
module fft_frame_scheduler #(
  parameter int INPUT_SIZE     = 16,
  parameter int NUM_POINTS     = 8,
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_scheduler_if.slave  host,
  output logic                  des_valid,
  output logic                  des_real_mode,
  output logic [INPUT_SIZE-1:0] des_data,
  input  logic                  des_done,
  output logic                  fft_start,
  input  logic                  fft_done,
  output logic                  ser_load,
  input  logic                  ser_busy,
  input  logic                  err_clear,
  output logic                  busy,
  output logic                  err_mode,
  output logic                  err_timeout,
  output logic [15:0]           frame_count
);

  localparam int BEATS_REAL = NUM_POINTS * WORD_SIZE / (2 * INPUT_SIZE);
  localparam int BEATS_CPLX = NUM_POINTS * WORD_SIZE / INPUT_SIZE;
  localparam int BW = $clog2(BEATS_CPLX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_REAL = BW'(BEATS_REAL - 1);
  localparam logic [BW-1:0] LAST_CPLX = BW'(BEATS_CPLX - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DES, COMPUTE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
  logic [TW-1:0]   to_cnt, to_cnt_nxt;
  logic            s_ready_q;
  logic            accept;
  logic            mode_mismatch;
  logic            start_nxt;
  logic            load_nxt;
  logic            timeout_evt;

  assign host.s_ready = s_ready_q;
  assign accept       = host.s_valid & s_ready_q;
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    to_cnt_nxt    = to_cnt;
    start_nxt     = 1'b0;
    load_nxt      = 1'b0;
    timeout_evt   = 1'b0;
    mode_mismatch = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          beat_cnt_nxt = BW'(1);
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          // Compared against the mode latched on the frame's first beat.
          mode_mismatch = (host.s_real_mode != des_real_mode);
          if (beat_cnt == (des_real_mode ? LAST_REAL : LAST_CPLX)) begin
            beat_cnt_nxt = '0;
            state_nxt    = WAIT_DES;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      WAIT_DES: begin
        if (des_done) begin
          start_nxt  = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = COMPUTE;
        end
      end
      COMPUTE: begin
        to_cnt_nxt = to_cnt + 1'b1;
        // fft_done is tested first so it wins over a same-cycle timeout.
        if (fft_done) begin
          if (!ser_busy) begin
            load_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (to_cnt == TO_LAST) begin
          timeout_evt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      DRAIN: begin
        if (!ser_busy) begin
          load_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      to_cnt        <= '0;
      s_ready_q     <= 1'b0;
      des_valid     <= 1'b0;
      des_real_mode <= 1'b0;
      des_data      <= '0;
      fft_start     <= 1'b0;
      ser_load      <= 1'b0;
      err_mode      <= 1'b0;
      err_timeout   <= 1'b0;
      frame_count   <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      // Ready follows the state being entered, so it drops the cycle after
      // the last beat and rises together with the return to IDLE.
      s_ready_q <= (state_nxt == IDLE) || (state_nxt == LOAD);
      des_valid <= accept;
      if (accept) des_data <= host.s_data;
      if (accept && (state == IDLE)) des_real_mode <= host.s_real_mode;
      fft_start <= start_nxt;
      ser_load  <= load_nxt;
      if (load_nxt) frame_count <= frame_count + 16'd1;
      // A new error takes priority over a same-cycle clear.
      if (mode_mismatch)  err_mode <= 1'b1;
      else if (err_clear) err_mode <= 1'b0;
      if (timeout_evt)    err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
module tb_fft_frame_scheduler;

  localparam int N_REAL  = 8 * 32 / (2 * 16);
  localparam int N_CPLX  = 8 * 32 / 16;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        des_valid, des_real_mode;
  logic [15:0] des_data;
  logic        des_done = 1'b0;
  logic        fft_start;
  logic        fft_done = 1'b0;
  logic        ser_load;
  logic        ser_busy = 1'b0;
  logic        err_clear = 1'b0;
  logic        busy, err_mode, err_timeout;
  logic [15:0] frame_count;

  fft_frame_scheduler_if #(.INPUT_SIZE(16)) hif ();

  fft_frame_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .host         (hif),
    .des_valid    (des_valid),
    .des_real_mode(des_real_mode),
    .des_data     (des_data),
    .des_done     (des_done),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .ser_load     (ser_load),
    .ser_busy     (ser_busy),
    .err_clear    (err_clear),
    .busy         (busy),
    .err_mode     (err_mode),
    .err_timeout  (err_timeout),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] data; logic mode; int cyc; } beat_t;
  typedef struct { int cyc; int cnt; } load_t;

  beat_t beat_q[$];
  int    start_q[$];
  load_t load_q[$];

  int checks = 0;
  int failures = 0;
  int model_count = 0;
  bit model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents an output.
  beat_t mb;
  load_t ml;
  int    ms;
  always @(negedge clk) begin
    if (!reset) begin
      if (des_valid) begin
        if (beat_q.size() == 0) chk("des_valid_unexpected", 32'(des_valid), 32'd0);
        else begin
          mb = beat_q.pop_front();
          chk("des_data", 32'(des_data), 32'(mb.data));
          chk("des_real_mode", 32'(des_real_mode), 32'(mb.mode));
          chk("des_valid_cycle", 32'(cyc), 32'(mb.cyc));
        end
      end
      if (fft_start) begin
        if (start_q.size() == 0) chk("fft_start_unexpected", 32'(fft_start), 32'd0);
        else begin
          ms = start_q.pop_front();
          chk("fft_start_cycle", 32'(cyc), 32'(ms));
        end
      end
      if (ser_load) begin
        if (load_q.size() == 0) chk("ser_load_unexpected", 32'(ser_load), 32'd0);
        else begin
          ml = load_q.pop_front();
          chk("ser_load_cycle", 32'(cyc), 32'(ml.cyc));
          chk("frame_count_at_load", 32'(frame_count), 32'(ml.cnt & 16'hFFFF));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted; expected output one cycle later
  // carrying the frame mode, not the beat's own mode.
  task automatic send_beat(input logic [15:0] d, input logic m, input logic frame_mode);
    int w = 0;
    hif.s_valid = 1'b1;
    hif.s_data = d;
    hif.s_real_mode = m;
    while (hif.s_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) chk("s_ready_wait_bound", 32'(hif.s_ready), 32'd1);
    beat_q.push_back('{data: d, mode: frame_mode, cyc: cyc + 1});
    tick();
    hif.s_valid = 1'b0;
  endtask

  // done_delay < 0: FFT core never answers.
  task automatic run_frame(input logic mode, input bit seq_data, input int gap_max, input int bad_idx,
                           input bit clr_bad, input int busy_cycles, input int done_delay);
    int n;
    int s;
    logic m;
    logic [15:0] d;
    n = mode ? N_REAL : N_CPLX;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
      if (i == 2) begin
        // Stray completions while loading must be ignored.
        des_done = 1'b1; fft_done = 1'b1;
        tick();
        des_done = 1'b0; fft_done = 1'b0;
      end
      m = (i == bad_idx) ? ~mode : mode;
      if (i == bad_idx) begin
        model_err = 1'b1;
        err_clear = clr_bad;
      end
      d = seq_data ? 16'(i + 1) : 16'($urandom);
      send_beat(d, m, mode);
      err_clear = 1'b0;
    end
    chk("s_ready_after_last_beat", 32'(hif.s_ready), 32'd0);
    chk("busy_wait_des", 32'(busy), 32'd1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    des_done = 1'b1;
    start_q.push_back(cyc + 1);
    tick();
    des_done = 1'b0;
    s = cyc;
    if (done_delay < 0) begin
      repeat (TIMEOUT - 1) tick();
      chk("timeout_not_yet", 32'(err_timeout), 32'd0);
      chk("busy_last_compute", 32'(busy), 32'd1);
      tick();
      chk("timeout_cycle", 32'(cyc - s), 32'(TIMEOUT));
      chk("err_timeout_set", 32'(err_timeout), 32'd1);
      chk("busy_after_timeout", 32'(busy), 32'd0);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      model_err = 1'b0;
      chk("err_timeout_cleared", 32'(err_timeout), 32'd0);
    end else begin
      if (busy_cycles > 0) ser_busy = 1'b1;
      repeat (done_delay) tick();
      fft_done = 1'b1;
      if (busy_cycles == 0) begin
        model_count++;
        load_q.push_back('{cyc: cyc + 1, cnt: model_count});
      end
      tick();
      fft_done = 1'b0;
      if (busy_cycles > 0) begin
        for (int b = 0; b < busy_cycles; b++) begin
          chk("drain_s_ready", 32'(hif.s_ready), 32'd0);
          chk("drain_busy", 32'(busy), 32'd1);
          tick();
        end
        ser_busy = 1'b0;
        model_count++;
        load_q.push_back('{cyc: cyc + 1, cnt: model_count});
        tick();
        chk("s_ready_back_in_idle", 32'(hif.s_ready), 32'd1);
      end
      chk("err_timeout_quiet", 32'(err_timeout), 32'd0);
    end
    chk("frame_count", 32'(frame_count), 32'(model_count & 16'hFFFF));
    chk("err_mode", 32'(err_mode), 32'(model_err));
    chk("beats_all_forwarded", 32'(beat_q.size()), 32'd0);
    chk("one_fft_start", 32'(start_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_s_ready", 32'(hif.s_ready), 32'd0);
    chk("rst_des_valid", 32'(des_valid), 32'd0);
    chk("rst_des_real_mode", 32'(des_real_mode), 32'd0);
    chk("rst_des_data", 32'(des_data), 32'd0);
    chk("rst_fft_start", 32'(fft_start), 32'd0);
    chk("rst_ser_load", 32'(ser_load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_mode", 32'(err_mode), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic mode;
    int   n;
    int   bad;
    hif.s_valid = 1'b0;
    hif.s_real_mode = 1'b0;
    hif.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    tick();
    chk("s_ready_first_idle", 32'(hif.s_ready), 32'd1);

    // Real frame, sequential data, continuous valid.
    run_frame(1'b1, 1'b1, 0, -1, 1'b0, 0, 2);
    // Complex frame with random valid gaps.
    run_frame(1'b0, 1'b0, 3, -1, 1'b0, 0, 4);
    // Serializer busy when the result is ready, released 5 cycles later.
    run_frame(1'b1, 1'b0, 1, -1, 1'b0, 5, 3);
    // FFT core never answers.
    run_frame(1'b0, 1'b0, 0, -1, 1'b0, 0, -1);
    // Beat 3 with the wrong mode, with err_clear in the same cycle.
    run_frame(1'b1, 1'b0, 0, 2, 1'b1, 0, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    model_err = 1'b0;
    chk("err_mode_cleared", 32'(err_mode), 32'd0);
    // fft_done on the last allowed COMPUTE cycle beats the timeout.
    run_frame(1'b0, 1'b0, 0, -1, 1'b0, 0, TIMEOUT - 1);

    // Reset in the middle of a complex frame.
    for (int i = 0; i < 5; i++) send_beat(16'($urandom), 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values();
    beat_q.delete();
    model_count = 0;
    model_err = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_frame(1'b0, 1'b0, 2, -1, 1'b0, 0, 3);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      mode = 1'($urandom_range(1, 0));
      n = mode ? N_REAL : N_CPLX;
      bad = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 1)) : -1;
      run_frame(mode, 1'b0, 2, bad, 1'b0, int'($urandom_range(3, 0)), int'($urandom_range(10, 0)));
      if (model_err) begin
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        model_err = 1'b0;
        chk("err_mode_cleared_rand", 32'(err_mode), 32'd0);
      end
    end

    tick();
    tick();
    chk("load_q_drained", 32'(load_q.size()), 32'd0);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
